// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and word-assembly constants.
package loader_pkg;

  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_MAX_WORDS = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN    = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } loaderStateT;

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes into one big-endian 32-bit word; the first byte
// ends up in bits [31:24].
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] wordOut,
  output logic        wordReady
);

  logic [1:0] byteCnt;

  // High on the cycle the last byte of a word is being accepted.
  assign wordReady = shiftEn && (byteCnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byteCnt <= 2'd0;
      wordOut <= 32'd0;
    end else if (clear) begin
      byteCnt <= 2'd0;
      wordOut <= 32'd0;
    end else if (shiftEn) begin
      byteCnt <= byteCnt + 2'd1;
      wordOut <= {wordOut[23:0], byteIn};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory while holding
// the CPU in reset; releases the CPU only after a complete, clean load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output loaderStateT       stateDbg
);

  localparam logic [8:0] MaxLen = 9'(MAX_WORDS);

  loaderStateT state, stateNext;
  logic [7:0]  wordIdx, wordCnt;
  logic        take, lenOk, packClear, packShift, wordReady;
  logic [31:0] packWord;
  logic        weNext, errNext, doneNext;

  // Handshake: a byte moves only on a cycle where byte_valid && byte_ready;
  // byte_ready depends on state alone, so a low byte_valid simply stalls.
  assign take      = byte_valid && byte_ready;
  assign lenOk     = (byte_data != 8'd0) && ({1'b0, byte_data} <= MaxLen);
  assign packShift = (state == DATA) && take && !abort;
  assign stateDbg  = state;

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (packClear),
    .shiftEn  (packShift),
    .byteIn   (byte_data),
    .wordOut  (packWord),
    .wordReady(wordReady)
  );

  always_comb begin
    stateNext  = state;
    byte_ready = 1'b0;
    weNext     = 1'b0;
    errNext    = 1'b0;
    doneNext   = 1'b0;
    packClear  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = LEN;
          packClear = 1'b1;
        end
      end
      LEN: begin
        byte_ready = 1'b1;
        if (abort) begin
          stateNext = IDLE;
          errNext   = 1'b1;
        end else if (take) begin
          if (lenOk) begin
            stateNext = DATA;
          end else begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (abort) begin
          stateNext = IDLE;
          errNext   = 1'b1;
          packClear = 1'b1;
        end else if (wordReady) begin
          stateNext = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          stateNext = IDLE;
          errNext   = 1'b1;
          packClear = 1'b1;
        end else begin
          weNext    = 1'b1;
          stateNext = ((wordIdx + 8'd1) < wordCnt) ? DATA : FINISH;
        end
      end
      FINISH: begin
        doneNext  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Strobes are registered, so the write lands the cycle after WRITE with
  // address and data latched alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wordIdx    <= 8'd0;
      wordCnt    <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state   <= stateNext;
      imem_we <= weNext;
      done    <= doneNext;
      err     <= errNext;
      if (state == IDLE && start) begin
        cpu_hold <= 1'b1;
        wordIdx  <= 8'd0;
      end
      if (state == LEN && take && !abort) begin
        wordCnt <= byte_data;
      end
      if (weNext) begin
        imem_addr  <= ADDR_W'({wordIdx, 2'b00});
        imem_wdata <= packWord;
        wordIdx    <= wordIdx + 8'd1;
      end
      if (doneNext) begin
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: length-vector table, directed corner sequences and
// random loads checked against a word-list model of the expected writes.
module tb_imem_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        byteValid = 1'b0;
  logic [7:0]  byteData = 8'd0;
  logic        byteReady, imemWe, cpuHold, done, err;
  logic [7:0]  imemAddr;
  logic [31:0] imemWdata;
  loaderStateT stateDbg;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected {addr, data} writes; monitor log of actual writes
  logic [39:0] exp_q[$];
  logic [39:0] actWr[$];
  int          rdIdx = 0;
  int          doneCnt = 0, errCnt = 0, longWe = 0;
  logic        prevWe = 1'b0;
  int          doneBase, errBase, wrBase;

  typedef struct {
    logic [7:0] lenByte;
    bit         expErr;
    int         expWrites;
  } lenVecT;
  lenVecT lenTbl[8];

  imem_loader #(.MAX_WORDS(64), .ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .byte_valid(byteValid),
    .byte_data (byteData),
    .byte_ready(byteReady),
    .imem_we   (imemWe),
    .imem_addr (imemAddr),
    .imem_wdata(imemWdata),
    .cpu_hold  (cpuHold),
    .done      (done),
    .err       (err),
    .stateDbg  (stateDbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imemWe) actWr.push_back({imemAddr, imemWdata});
    if (imemWe && prevWe) longWe++;
    prevWe <= imemWe;
    if (done) doneCnt++;
    if (err) errCnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitReady();
    int waitCyc = 0;
    @(negedge clk);
    while (!byteReady && waitCyc < 100) begin
      waitCyc++;
      @(negedge clk);
    end
    if (!byteReady) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: got ready=0 expected ready=1 within 100 cycles");
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    byteValid = 1'b1;
    byteData  = b;
    waitReady();
    @(posedge clk); #1;
    byteValid = 1'b0;
  endtask

  task automatic sendByteAbort(input logic [7:0] b);
    byteValid = 1'b1;
    byteData  = b;
    waitReady();
    abort = 1'b1;
    @(posedge clk); #1;
    abort     = 1'b0;
    byteValid = 1'b0;
  endtask

  // Model: word w is the big-endian value of its four bytes, written at 4*w.
  task automatic loadWords(input int firstWord, input int n, input int gapMin, input int gapMax);
    int unsigned b[4];
    int unsigned word;
    for (int w = firstWord; w < firstWord + n; w++) begin
      for (int j = 0; j < 4; j++) begin
        b[j] = $urandom_range(255, 0);
        repeat ($urandom_range(gapMax, gapMin)) begin
          @(posedge clk); #1;
        end
        sendByte(8'(b[j]));
      end
      word = b[0] * 32'h0100_0000 + b[1] * 32'h0001_0000 + b[2] * 256 + b[3];
      exp_q.push_back({8'(w * 4), word});
    end
  endtask

  task automatic beginLoad();
    doneBase = doneCnt;
    errBase  = errCnt;
    wrBase   = actWr.size();
    pulseStart();
  endtask

  task automatic checkWrites(input string name);
    logic [39:0] e;
    check({name, " write count"}, 64'(actWr.size() - rdIdx), 64'(exp_q.size()));
    while (exp_q.size() > 0 && rdIdx < actWr.size()) begin
      e = exp_q.pop_front();
      check({name, " write"}, 64'(actWr[rdIdx]), 64'(e));
      rdIdx++;
    end
    exp_q.delete();
    rdIdx = actWr.size();
  endtask

  task automatic endLoad(input string name, input int expDone, input int expErr, input logic expHold);
    settle(4);
    checkWrites(name);
    check({name, " done pulses"}, 64'(doneCnt - doneBase), 64'(expDone));
    check({name, " err pulses"}, 64'(errCnt - errBase), 64'(expErr));
    check({name, " cpu_hold"}, 64'(cpuHold), 64'(expHold));
    check({name, " state idle"}, 64'(stateDbg), 64'(IDLE));
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, " byte_ready"}, 64'(byteReady), 64'(0));
    check({name, " imem_we"}, 64'(imemWe), 64'(0));
    check({name, " imem_addr"}, 64'(imemAddr), 64'(0));
    check({name, " imem_wdata"}, 64'(imemWdata), 64'(0));
    check({name, " cpu_hold"}, 64'(cpuHold), 64'(0));
    check({name, " done"}, 64'(done), 64'(0));
    check({name, " err"}, 64'(err), 64'(0));
    check({name, " state"}, 64'(stateDbg), 64'(IDLE));
  endtask

  initial begin
    lenTbl[0] = '{8'd0,   1'b1, 0};
    lenTbl[1] = '{8'd1,   1'b0, 1};
    lenTbl[2] = '{8'd2,   1'b0, 2};
    lenTbl[3] = '{8'd64,  1'b0, 64};
    lenTbl[4] = '{8'd65,  1'b1, 0};
    lenTbl[5] = '{8'd255, 1'b1, 0};
    lenTbl[6] = '{8'd128, 1'b1, 0};
    lenTbl[7] = '{8'd7,   1'b0, 7};

    #12;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    settle(2);

    // two-word program from the reference stream
    beginLoad();
    check("hold after start", 64'(cpuHold), 64'(1));
    sendByte(8'h02);
    sendByte(8'h20); sendByte(8'h08); sendByte(8'h00); sendByte(8'h05);
    sendByte(8'h8C); sendByte(8'h01); sendByte(8'h00); sendByte(8'h04);
    exp_q.push_back({8'h00, 32'h2008_0005});
    exp_q.push_back({8'h04, 32'h8C01_0004});
    endLoad("basic", 1, 0, 1'b0);

    // bad lengths
    beginLoad();
    sendByte(8'h00);
    endLoad("len00", 0, 1, 1'b1);
    beginLoad();
    sendByte(8'h41);
    endLoad("len41", 0, 1, 1'b1);

    // abort and start in IDLE are inert apart from start
    errBase = errCnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    settle(2);
    check("idle abort err", 64'(errCnt - errBase), 64'(0));
    check("idle abort state", 64'(stateDbg), 64'(IDLE));

    // length table
    for (int i = 0; i < 8; i++) begin
      beginLoad();
      sendByte(lenTbl[i].lenByte);
      if (!lenTbl[i].expErr) loadWords(0, int'(lenTbl[i].lenByte), 0, 0);
      settle(4);
      check("tbl writes", 64'(actWr.size() - wrBase), 64'(lenTbl[i].expWrites));
      endLoad("tbl", lenTbl[i].expErr ? 0 : 1, lenTbl[i].expErr ? 1 : 0, lenTbl[i].expErr);
    end

    // full-size load with valid toggling every other cycle
    beginLoad();
    sendByte(8'd64);
    loadWords(0, 64, 1, 1);
    settle(4);
    check("n64 last addr", 64'(actWr[actWr.size() - 1][39:32]), 64'(8'hFC));
    endLoad("n64", 1, 0, 1'b0);

    // abort coinciding with the 8th byte of a 3-word load
    beginLoad();
    sendByte(8'd3);
    loadWords(0, 1, 0, 0);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    sendByteAbort(8'h44);
    endLoad("abort8", 0, 1, 1'b1);

    // abort while in WRITE suppresses that write
    beginLoad();
    sendByte(8'd1);
    sendByte(8'hA1); sendByte(8'hA2); sendByte(8'hA3); sendByte(8'hA4);
    check("in write", 64'(stateDbg), 64'(WRITE));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    endLoad("abortw", 0, 1, 1'b1);

    // asynchronous reset in the middle of word 1
    beginLoad();
    sendByte(8'd2);
    sendByte(8'hDE); sendByte(8'hAD); sendByte(8'hBE); sendByte(8'hEF);
    exp_q.push_back({8'h00, 32'hDEAD_BEEF});
    sendByte(8'h12); sendByte(8'h34);
    #3 reset = 1'b0;
    #2;
    checkResetOutputs("async rst");
    @(posedge clk); #1;
    reset = 1'b1;
    endLoad("rst mid", 0, 0, 1'b0);
    beginLoad();
    sendByte(8'd1);
    loadWords(0, 1, 0, 0);
    endLoad("after rst", 1, 0, 1'b0);

    // start during DATA is ignored
    beginLoad();
    sendByte(8'd2);
    sendByte(8'h11); sendByte(8'h22);
    pulseStart();
    sendByte(8'h33); sendByte(8'h44);
    sendByte(8'h55); sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
    exp_q.push_back({8'h00, 32'h1122_3344});
    exp_q.push_back({8'h04, 32'h5566_7788});
    endLoad("start in data", 1, 0, 1'b0);

    // random loads with random stalls
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(8, 1);
      beginLoad();
      sendByte(8'(n));
      loadWords(0, n, 0, 2);
      endLoad("random", 1, 0, 1'b0);
    end

    check("we single cycle", 64'(longWe), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 64, max words per load (256-byte space / 4).
REQ-002 SHALL have parameter ADDR_W, default 8, width of the instruction-memory byte address (matches PC width).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port abort  input  1  single-cycle request to cancel a load in progress.
REQ-007 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-008 SHALL have port byte_data  input  8  incoming stream byte.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  ADDR_W  word-aligned byte address of the write.
REQ-012 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-013 SHALL have port cpu_hold  output  1  holds the PC in reset while high.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful load completion.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a bad length or an abort.

Function
REQ-016 SHALL implement FSM states IDLE, LEN, DATA, WRITE, FINISH.
REQ-017 IDLE: byte_ready=0; start -> LEN, cpu_hold set to 1 on the same edge.
REQ-018 LEN: byte_ready=1; accepted byte (valid&ready) is word count N; 1<=N<=MAX_WORDS -> DATA, else err pulse -> IDLE.
REQ-019 DATA: byte_ready=1; accepts 4 bytes per word, big-endian (first byte -> wdata[31:24], fourth -> [7:0]); 4th byte accepted -> WRITE.
REQ-020 WRITE: byte_ready=0; imem_we=1 for exactly one cycle with imem_addr=4*k (k = word index from 0) and the assembled word.
REQ-021 WRITE exit: if k+1<N -> DATA with k incremented, else -> FINISH.
REQ-022 FINISH: done=1 for one cycle, cpu_hold cleared to 0, next state IDLE.
REQ-023 Handshake: a byte transfers only on a cycle with byte_valid=1 and byte_ready=1; byte_valid low stalls indefinitely with no state change.
REQ-024 imem_addr SHALL advance by 4 per word and never wrap; N<=MAX_WORDS guarantees last address 4*(N-1)<=252.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 abort in LEN, DATA or WRITE SHALL go to IDLE, pulse err, suppress any imem_we on that cycle, and discard partial word bytes.
REQ-027 Simultaneous abort and final byte SHALL give abort priority (no write, no done).
REQ-028 After err, cpu_hold SHALL stay 1 (memory contents undefined) until a later load reaches FINISH.
REQ-029 abort in IDLE or FINISH SHALL be ignored.
REQ-030 imem_we, done, err SHALL be registered outputs; imem_addr/imem_wdata stable whenever imem_we=1.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, clear k, N, byte counter and word register.
REQ-032 Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, err=0.
REQ-033 Reset mid-load SHALL abandon the load with no further imem_we and no done/err pulse.

Structure
REQ-034 Shared package loader_pkg SHALL hold the state enumeration, BYTES_PER_WORD=4, and default MAX_WORDS.
REQ-035 Byte-to-word assembly SHALL be a sub-module byte_packer (2-bit byte counter, 32-bit shift register, word_ready flag, clear input).

Verification
REQ-036 start; stream 02,20,08,00,05,8C,01,00,04 -> writes 0x20080005 @0x00 and 0x8C010004 @0x04, done pulse, cpu_hold 1->0.
REQ-037 start; length byte 00, then separately 41 -> err pulse each time, no imem_we, return to IDLE, cpu_hold stays 1.
REQ-038 N=64 with byte_valid toggling every other cycle -> 64 writes, last @0xFC, no address wrap, single done.
REQ-039 N=3, abort asserted on the cycle the 8th byte is accepted -> one write only (@0x00), err pulse, no done, cpu_hold=1.
REQ-040 reset driven low during DATA of word 1 -> all outputs at reset values asynchronously; subsequent N=1 load completes normally.
REQ-041 start pulsed during DATA -> ignored; load completes with original N and addresses.
